// File: rtl/icache_ctrl_2way.sv
// icache_ctrl_2way
// Sequencing controller for a 2-way set-associative, read-only instruction cache
// built from two 256-line x 4-word sets.
// It turns fetches into lookups and detects hits. On a miss it picks a victim way
// (an invalid way first, otherwise per-index LRU), runs the 4-beat line fill,
// validates the line and then replays the fetch. It also sequences index-invalidate
// operations.
//
// Ports
//   clock, reset            system clock, asynchronous active-low reset
//   Read, Index, Offset     fetch request and its line index / word offset
//   Tag                     physical tag, valid the cycle after Read, held while Stall=1
//   Inv_Req                 index-invalidate request (uses Index)
//   Hit0/1, Valid0/1        per-way tag match / valid from the sets (one-cycle delayed)
//   Mem_Valid               one fill word present on the sets' LineIn bus
//   Set_Index, Set_Offset   lookup address driven to both sets
//   Ready, WaySel, Stall    fetch handshake: data valid, selected way, hold fetch
//   Mem_Req, Mem_Addr       line fill request (level) and line address {Tag, index}
//   FillLine0/1             per-way fill write strobe
//   LineIndex, LineOffset   fill write address
//   ValidateLine0/1         per-way validate strobe
//   InvalidateLine0/1       per-way invalidate strobe
//   Inv_Done                one-cycle invalidate completion pulse

module icache_ctrl_2way #(
  parameter int unsigned PABITS = 36
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Read,
  input  logic [7:0]        Index,
  input  logic [1:0]        Offset,
  input  logic [PABITS-13:0] Tag,
  input  logic              Inv_Req,
  input  logic              Hit0,
  input  logic              Hit1,
  input  logic              Valid0,
  input  logic              Valid1,
  input  logic              Mem_Valid,
  output logic [7:0]        Set_Index,
  output logic [1:0]        Set_Offset,
  output logic              Ready,
  output logic              WaySel,
  output logic              Stall,
  output logic              Mem_Req,
  output logic [PABITS-5:0] Mem_Addr,
  output logic              FillLine0,
  output logic              FillLine1,
  output logic [7:0]        LineIndex,
  output logic [1:0]        LineOffset,
  output logic              ValidateLine0,
  output logic              ValidateLine1,
  output logic              InvalidateLine0,
  output logic              InvalidateLine1,
  output logic              Inv_Done
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StFill,
    StValidate,
    StReplay,
    StInv
  } stateE;

  stateE              state;
  logic [7:0]         capIndex;
  logic [1:0]         capOffset;
  logic               victim;
  logic [1:0]         beat;
  logic [255:0]       lru;       // per-index way to evict next
  logic               memReq;
  logic [PABITS-5:0]  memAddr;
  logic               invDone;

  logic lookupHit;
  logic hitWay;
  logic missVictim;
  logic fillStrobe;

  // Way 0 wins a double hit.
  assign lookupHit  = (state == StLookup) && (Hit0 || Hit1);
  assign hitWay     = Hit1 & ~Hit0;
  // Invalid ways are filled before any valid line is evicted.
  assign missVictim = !Valid0 ? 1'b0 : (!Valid1 ? 1'b1 : lru[capIndex]);
  assign fillStrobe = (state == StFill) && Mem_Valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      capIndex  <= '0;
      capOffset <= '0;
      victim    <= 1'b0;
      beat      <= '0;
      lru       <= '0;
      memReq    <= 1'b0;
      memAddr   <= '0;
      invDone   <= 1'b0;
    end else begin
      invDone <= (state == StInv);
      unique case (state)
        StIdle: begin
          if (Inv_Req) begin
            capIndex <= Index;
            state    <= StInv;
          end else if (Read) begin
            capIndex  <= Index;
            capOffset <= Offset;
            state     <= StLookup;
          end
        end
        StLookup: begin
          if (lookupHit) begin
            lru[capIndex] <= ~hitWay;
            if (Read) begin
              capIndex  <= Index;
              capOffset <= Offset;
            end else if (Inv_Req) begin
              capIndex <= Index;
              state    <= StInv;
            end else begin
              state <= StIdle;
            end
          end else begin
            victim  <= missVictim;
            memReq  <= 1'b1;
            memAddr <= {Tag, capIndex};
            beat    <= '0;
            state   <= StFill;
          end
        end
        StFill: begin
          if (Mem_Valid) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              memReq <= 1'b0;
              state  <= StValidate;
            end
          end
        end
        StValidate: begin
          lru[capIndex] <= ~victim;
          state         <= StReplay;
        end
        StReplay: begin
          state <= StLookup;
        end
        StInv: begin
          lru[capIndex] <= 1'b0;
          state         <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Sets follow the live fetch address while idle or looking up, so back-to-back
  // hits keep one lookup per cycle; otherwise they see the captured address.
  assign Set_Index  = (state == StIdle || state == StLookup) ? Index : capIndex;
  assign Set_Offset = (state == StIdle || state == StLookup) ? Offset : capOffset;

  assign Ready  = lookupHit;
  assign WaySel = lookupHit & hitWay;
  assign Stall  = ((state == StLookup) && !lookupHit) || (state == StFill) ||
                  (state == StValidate) || (state == StReplay);

  assign Mem_Req  = memReq;
  assign Mem_Addr = memAddr;

  assign FillLine0  = fillStrobe & ~victim;
  assign FillLine1  = fillStrobe & victim;
  assign LineIndex  = capIndex;
  assign LineOffset = beat;

  assign ValidateLine0 = (state == StValidate) & ~victim;
  assign ValidateLine1 = (state == StValidate) & victim;

  assign InvalidateLine0 = (state == StInv);
  assign InvalidateLine1 = (state == StInv);
  assign Inv_Done        = invDone;

endmodule

// File: tb/tb_icache_ctrl_2way.sv
// Directed bench for icache_ctrl_2way: miss/fill/validate/replay on both ways,
// back-to-back hits, double hit, invalidate priority, and reset during a fill.
module tb_icache_ctrl_2way;

  localparam int unsigned PABITS = 36;

  logic              clock;
  logic              reset;
  logic              Read;
  logic [7:0]        Index;
  logic [1:0]        Offset;
  logic [PABITS-13:0] Tag;
  logic              Inv_Req;
  logic              Hit0, Hit1, Valid0, Valid1;
  logic              Mem_Valid;
  logic [7:0]        Set_Index;
  logic [1:0]        Set_Offset;
  logic              Ready, WaySel, Stall, Mem_Req;
  logic [PABITS-5:0] Mem_Addr;
  logic              FillLine0, FillLine1;
  logic [7:0]        LineIndex;
  logic [1:0]        LineOffset;
  logic              ValidateLine0, ValidateLine1;
  logic              InvalidateLine0, InvalidateLine1;
  logic              Inv_Done;

  int nChecks = 0;
  int nPass   = 0;

  icache_ctrl_2way #(.PABITS(PABITS)) dut (
    .clock           (clock),
    .reset           (reset),
    .Read            (Read),
    .Index           (Index),
    .Offset          (Offset),
    .Tag             (Tag),
    .Inv_Req         (Inv_Req),
    .Hit0            (Hit0),
    .Hit1            (Hit1),
    .Valid0          (Valid0),
    .Valid1          (Valid1),
    .Mem_Valid       (Mem_Valid),
    .Set_Index       (Set_Index),
    .Set_Offset      (Set_Offset),
    .Ready           (Ready),
    .WaySel          (WaySel),
    .Stall           (Stall),
    .Mem_Req         (Mem_Req),
    .Mem_Addr        (Mem_Addr),
    .FillLine0       (FillLine0),
    .FillLine1       (FillLine1),
    .LineIndex       (LineIndex),
    .LineOffset      (LineOffset),
    .ValidateLine0   (ValidateLine0),
    .ValidateLine1   (ValidateLine1),
    .InvalidateLine0 (InvalidateLine0),
    .InvalidateLine1 (InvalidateLine1),
    .Inv_Done        (Inv_Done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called in the first FILL cycle; returns in the following LOOKUP cycle.
  task automatic doFill(input logic way, input logic [7:0] idx, input logic [1:0] off);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        Mem_Valid = 1'b0;
        #1;
        check("fill gap strobe", {FillLine1, FillLine0}, 2'b00);
        step();
      end
      Mem_Valid = 1'b1;
      #1;
      check("fill strobe", {FillLine1, FillLine0}, way ? 2'b10 : 2'b01);
      check("fill offset", LineOffset, b[1:0]);
      check("fill index", LineIndex, idx);
      check("fill memreq", Mem_Req, 1'b1);
      step();
    end
    Mem_Valid = 1'b0;
    #1;
    check("validate memreq", Mem_Req, 1'b0);
    check("validate strobe", {ValidateLine1, ValidateLine0}, way ? 2'b10 : 2'b01);
    check("validate stall", Stall, 1'b1);
    check("validate setidx", Set_Index, idx);
    step();
    check("replay stall", Stall, 1'b1);
    check("replay validate", {ValidateLine1, ValidateLine0}, 2'b00);
    check("replay setaddr", {Set_Index, Set_Offset}, {idx, off});
    step();
  endtask

  initial begin
    reset = 1'b0; Read = 1'b0; Index = '0; Offset = '0; Tag = '0; Inv_Req = 1'b0;
    Hit0 = 1'b0; Hit1 = 1'b0; Valid0 = 1'b0; Valid1 = 1'b0; Mem_Valid = 1'b0;
    #2;
    check("rst outs", {Ready, WaySel, Stall, Mem_Req, Inv_Done}, 5'b0);
    check("rst addr", Mem_Addr, 32'h0);
    check("rst strobes", {FillLine0, FillLine1, ValidateLine0, ValidateLine1,
                          InvalidateLine0, InvalidateLine1}, 6'b0);
    step();
    reset = 1'b1;

    // Miss into an empty set: fill way 0, then hit -> LRU[5]=1.
    step();
    Read = 1'b1; Index = 8'h05; Offset = 2'd2;
    step();
    Read = 1'b0; Tag = 24'h000123;
    #1;
    check("miss stall", Stall, 1'b1);
    check("miss ready", Ready, 1'b0);
    step();
    check("fill memreq", Mem_Req, 1'b1);
    check("fill memaddr", Mem_Addr, 32'h00012305);
    doFill(1'b0, 8'h05, 2'd2);
    Hit0 = 1'b1;
    #1;
    check("replay hit ready", Ready, 1'b1);
    check("replay hit waysel", WaySel, 1'b0);
    check("replay hit stall", Stall, 1'b0);
    step();
    Hit0 = 1'b0;

    // Both valid, LRU[5]=1 -> victim way 1.
    Read = 1'b1; Index = 8'h05; Offset = 2'd1;
    step();
    Read = 1'b0; Valid0 = 1'b1; Valid1 = 1'b1; Tag = 24'h000456;
    step();
    check("way1 memaddr", Mem_Addr, 32'h00045605);
    doFill(1'b1, 8'h05, 2'd1);
    Hit1 = 1'b1;
    #1;
    check("way1 hit", {Ready, WaySel}, 2'b11);
    step();
    Hit1 = 1'b0;

    // Back-to-back hits on way 1.
    Read = 1'b1; Index = 8'h10; Offset = 2'd0;
    step();
    for (int i = 0; i < 3; i++) begin
      Hit1 = 1'b1;
      Read = (i < 2);
      Index = 8'h11 + 8'(i);
      #1;
      check("b2b ready", {Ready, WaySel, Stall}, 3'b110);
      check("b2b setidx", Set_Index, 8'h11 + 8'(i));
      step();
    end
    Hit1 = 1'b0;
    #1;
    check("b2b idle", {Ready, Stall}, 2'b00);

    // Double hit: way 0 wins, LRU[0x20] becomes 1.
    Read = 1'b1; Index = 8'h20; Offset = 2'd3;
    step();
    Read = 1'b0; Hit0 = 1'b1; Hit1 = 1'b1;
    #1;
    check("dbl hit", {Ready, WaySel}, 2'b10);
    step();
    Hit0 = 1'b0; Hit1 = 1'b0;

    // Invalidate takes priority over a simultaneous Read; Read ignored in INV.
    Read = 1'b1; Inv_Req = 1'b1; Index = 8'h7F;
    step();
    Inv_Req = 1'b0; Index = 8'h33;
    #1;
    check("inv strobes", {InvalidateLine1, InvalidateLine0}, 2'b11);
    check("inv setidx", Set_Index, 8'h7F);
    check("inv outs", {Ready, Stall, Inv_Done, Mem_Req}, 4'b0);
    step();
    Read = 1'b0;
    #1;
    check("inv done", Inv_Done, 1'b1);
    check("inv strobes off", {InvalidateLine1, InvalidateLine0}, 2'b00);
    step();
    check("inv done pulse", Inv_Done, 1'b0);

    // Reset after two fill beats aborts the fill.
    Read = 1'b1; Index = 8'h09; Offset = 2'd0;
    step();
    Read = 1'b0; Valid0 = 1'b0; Valid1 = 1'b0;
    step();
    Mem_Valid = 1'b1;
    step();
    step();
    Mem_Valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort memreq", {Mem_Req, Stall}, 2'b00);
    step();
    check("abort validate", {ValidateLine1, ValidateLine0}, 2'b00);
    reset = 1'b1;
    step();

    // LRU[0x20] was 1 before reset; a cleared LRU picks way 0.
    Read = 1'b1; Index = 8'h20; Offset = 2'd1;
    step();
    Read = 1'b0; Valid0 = 1'b1; Valid1 = 1'b1; Tag = 24'h000ABC;
    #1;
    check("post-rst miss stall", Stall, 1'b1);
    step();
    check("post-rst memaddr", Mem_Addr, 32'h000ABC20);
    doFill(1'b0, 8'h20, 2'd1);
    Hit0 = 1'b1;
    #1;
    check("post-rst hit", {Ready, WaySel}, 2'b10);
    step();
    Hit0 = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
